// File: rtl/uart_rx_ctrl_if.sv
// Frame-result bundle from the UART RX controller to its consumer.
// The controller drives it through the master modport.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  strt_glitch;

  modport master (
    output p_data,
    output data_valid,
    output par_err,
    output stp_err,
    output strt_glitch
  );

  modport slave (
    input p_data,
    input data_valid,
    input par_err,
    input stp_err,
    input strt_glitch
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start/parity/stop checking, mid-bit majority
// sampling and LSB-first deserialization driven by an external edge/bit counter.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_in,
  input  logic [5:0]     prescale,
  input  logic           par_en,
  input  logic           par_typ,
  input  logic [5:0]     edge_cnt,
  input  logic [3:0]     bit_cnt,
  output logic           cnt_enable,
  uart_rx_ctrl_if.master rx_if
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0]            votes;
  logic                  par_flag;

  logic                  prescale_ok;
  logic [5:0]            half;
  logic                  last_edge;
  logic                  sample;
  logic                  exp_par;
  logic                  frame_perr;

  always_comb begin
    prescale_ok = 1'b0;
    case (prescale)
      6'd4, 6'd8, 6'd16, 6'd32: prescale_ok = 1'b1;
      default:                  prescale_ok = 1'b0;
    endcase
  end

  assign half       = prescale >> 1;
  assign last_edge  = (edge_cnt == prescale);
  assign sample     = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
  assign exp_par    = (^shift_reg) ^ par_typ;
  assign frame_perr = par_flag & par_en;
  assign cnt_enable = (state != IDLE);

  // Three mid-bit captures; they complete before the last edge for every legal prescale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      votes <= '0;
    end else if (state != IDLE) begin
      if (edge_cnt == half - 6'd1) votes[0] <= rx_in;
      if (edge_cnt == half)        votes[1] <= rx_in;
      if (edge_cnt == half + 6'd1) votes[2] <= rx_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      shift_reg         <= '0;
      par_flag          <= 1'b0;
      rx_if.p_data      <= '0;
      rx_if.data_valid  <= 1'b0;
      rx_if.par_err     <= 1'b0;
      rx_if.stp_err     <= 1'b0;
      rx_if.strt_glitch <= 1'b0;
    end else begin
      rx_if.data_valid  <= 1'b0;
      rx_if.par_err     <= 1'b0;
      rx_if.stp_err     <= 1'b0;
      rx_if.strt_glitch <= 1'b0;

      case (state)
        IDLE: begin
          par_flag <= 1'b0;
          if (!rx_in && prescale_ok) state <= START;
        end

        START: begin
          if (last_edge) begin
            if (sample) begin
              state             <= IDLE;
              rx_if.strt_glitch <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (last_edge) begin
            shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA) state <= par_en ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (last_edge) begin
            par_flag <= sample ^ exp_par;
            state    <= STOP;
          end
        end

        STOP: begin
          if (last_edge) begin
            state            <= IDLE;
            rx_if.stp_err    <= ~sample;
            rx_if.par_err    <= frame_perr;
            rx_if.data_valid <= sample & ~frame_perr;
            if (sample && !frame_perr) rx_if.p_data <= shift_reg;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural edge/bit counter and a
// pulse logger; expected cycles and bytes are hand-computed per frame.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       cnt_enable;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_enable (cnt_enable),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream edge/bit counter: edge 1 / bit 0 while disabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= 4'd0;
    end else if (!cnt_enable) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= 4'd0;
    end else if (edge_cnt == prescale) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  int         dv_n = 0, pe_n = 0, se_n = 0, gl_n = 0;
  int         pe_cy = 0, se_cy = 0, gl_cy = 0;
  int         dv_cy [16];
  logic [7:0] dv_val [16];

  always @(negedge clk) begin
    if (rx_if.data_valid) begin
      dv_cy[dv_n % 16]  = cyc;
      dv_val[dv_n % 16] = rx_if.p_data;
      dv_n++;
    end
    if (rx_if.par_err)     begin pe_cy = cyc; pe_n++; end
    if (rx_if.stp_err)     begin se_cy = cyc; se_n++; end
    if (rx_if.strt_glitch) begin gl_cy = cyc; gl_n++; end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int b_dv, b_pe, b_se, b_gl;
  task automatic snap();
    b_dv = dv_n; b_pe = pe_n; b_se = se_n; b_gl = gl_n;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold(input logic b, input int unsigned n);
    rx_in = b;
    wait_cycles(n);
  endtask

  // t is the cycle in which the start bit is first presented on the line.
  task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic pen,
                            input logic pbit, input logic sbit, output int t);
    @(posedge clk); #1;
    t = cyc;
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    if (pen) hold(pbit, p);
    hold(sbit, p);
    rx_in = 1'b1;
  endtask

  int t, t1, t2;

  initial begin
    wait_cycles(3);
    check_eq("rst_cnt_en", cnt_enable, 1'b0);
    check_eq("rst_p_data", rx_if.p_data, 8'h00);
    check_eq("rst_dv", rx_if.data_valid, 1'b0);
    check_eq("rst_errs", {rx_if.par_err, rx_if.stp_err, rx_if.strt_glitch}, 3'b000);
    rst = 1'b1;
    wait_cycles(3);

    // 0xA5, even parity bit 0, good stop
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, t);
    wait_cycles(16);
    check_eq("a5_dv_cnt", dv_n - b_dv, 1);
    check_eq("a5_dv_cyc", dv_cy[b_dv % 16], t + 89);
    check_eq("a5_data", dv_val[b_dv % 16], 8'hA5);
    check_eq("a5_no_err", (pe_n - b_pe) + (se_n - b_se), 0);

    // same frame under odd parity
    par_typ = 1'b1;
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, t);
    wait_cycles(16);
    check_eq("odd_pe_cnt", pe_n - b_pe, 1);
    check_eq("odd_pe_cyc", pe_cy, t + 89);
    check_eq("odd_no_dv", dv_n - b_dv, 0);
    check_eq("odd_p_data_kept", rx_if.p_data, 8'hA5);

    // p=16, no parity, stop bit 0
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    snap();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, t);
    wait_cycles(32);
    check_eq("stp_se_cnt", se_n - b_se, 1);
    check_eq("stp_se_cyc", se_cy, t + 161);
    check_eq("stp_no_dv", dv_n - b_dv, 0);
    check_eq("stp_no_pe", pe_n - b_pe, 0);
    check_eq("stp_p_data_kept", rx_if.p_data, 8'hA5);

    // false start: two low cycles
    prescale = 6'd8;
    snap();
    @(posedge clk); #1;
    t = cyc;
    hold(1'b0, 2);
    rx_in = 1'b1;
    wait_cycles(20);
    check_eq("gl_cnt", gl_n - b_gl, 1);
    check_eq("gl_cyc", gl_cy, t + 9);
    check_eq("gl_idle", cnt_enable, 1'b0);
    check_eq("gl_no_frame", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se), 0);

    snap();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, t);
    wait_cycles(16);
    check_eq("5a_dv_cnt", dv_n - b_dv, 1);
    check_eq("5a_dv_cyc", dv_cy[b_dv % 16], t + 81);
    check_eq("5a_data", dv_val[b_dv % 16], 8'h5A);

    // reset asserted mid-DATA
    @(posedge clk); #1;
    hold(1'b0, 20);
    check_eq("mid_cnt_en", cnt_enable, 1'b1);
    snap();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_cnt_en", cnt_enable, 1'b0);
    check_eq("mid_rst_p_data", rx_if.p_data, 8'h00);
    hold(1'b1, 5);
    check_eq("mid_rst_outs", {rx_if.data_valid, rx_if.par_err, rx_if.stp_err, rx_if.strt_glitch}, 4'h0);
    rst = 1'b1;
    wait_cycles(40);
    check_eq("mid_no_pulse", (dv_n - b_dv) + (pe_n - b_pe) + (se_n - b_se) + (gl_n - b_gl), 0);

    prescale = 6'd4;
    snap();
    send_frame(8'h81, 4, 1'b0, 1'b0, 1'b1, t);
    wait_cycles(10);
    check_eq("81_dv_cnt", dv_n - b_dv, 1);
    check_eq("81_dv_cyc", dv_cy[b_dv % 16], t + 41);
    check_eq("81_data", dv_val[b_dv % 16], 8'h81);

    // illegal prescale: line ignored
    prescale = 6'd6;
    snap();
    hold(1'b0, 12);
    check_eq("ill_cnt_en", cnt_enable, 1'b0);
    rx_in = 1'b1;
    wait_cycles(4);
    check_eq("ill_no_pulse", (gl_n - b_gl) + (dv_n - b_dv), 0);

    // back-to-back at p=32
    prescale = 6'd32;
    snap();
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, t1);
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, t2);
    wait_cycles(64);
    check_eq("b2b_dv_cnt", dv_n - b_dv, 2);
    check_eq("b2b_cyc0", dv_cy[b_dv % 16], t1 + 321);
    check_eq("b2b_data0", dv_val[b_dv % 16], 8'hFF);
    check_eq("b2b_cyc1", dv_cy[(b_dv + 1) % 16], t2 + 321);
    check_eq("b2b_data1", dv_val[(b_dv + 1) % 16], 8'h00);
    check_eq("b2b_no_err", (pe_n - b_pe) + (se_n - b_se) + (gl_n - b_gl), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
